pe_dot_pipe: RTL and testbench
==============================

// Module: pe_dot_pipe
// PURPOSE
// - Pipelined block-floating-point dot-product engine; the producer of the dot results that pe_dot_checker verifies.
// - Per lane: one DOT_SIZE-element dot product of sign-magnitude feature and filter mantissas.
// - Lanes: NUM_DOTS x NUM_FEATURES x NUM_FILTERS, all computed every cycle.
// - Sits inside each PE, between the feature bus / filter cache read port and the accumulator.
// - Exponents are ignored here; downstream logic handles them.
// PARAMETERS
// - cfg               pe_cfg_t  (no default)  fields used below
// - cfg.NUM_DOTS          1   dot groups per PE
// - cfg.NUM_FEATURES      2   feature vectors per dot group
// - cfg.NUM_FILTERS       2   filter vectors per dot group
// - cfg.DOT_SIZE          8   elements per dot product
// - cfg.FEATURE_WIDTH     6   feature mantissa width: MSB = sign, rest = magnitude
// - cfg.FILTER_WIDTH      6   filter mantissa width: MSB = sign, rest = magnitude
// - cfg.DOT_OUTPUT_WIDTH  16  result width, two's complement
// - cfg.DOT_LATENCY       4   input-to-output cycles; must be >= 3
// - CHAIN_ID              0   chain index, used for debug only
// - PE_ID                 0   PE index, used for debug only
// PORTS
// - clock         in   1        rising-edge clock; the single clock domain
// - reset         in   1        synchronous, active-high reset
// - i_valid       in   1        i_feature / i_filter hold a valid vector this cycle
// - i_feature     in   feature_bus_t#(cfg)::t            mantissa field used
// - i_filter      in   filter_cache_read_data_t#(cfg)::t mantissa field used
// - o_valid       out  1        i_valid delayed by exactly DOT_LATENCY cycles
// - o_dot_result  out  [DOT_OUTPUT_WIDTH-1:0] [NUM_DOTS][NUM_FEATURES][NUM_FILTERS]  dot results
// BEHAVIOUR
// - Lane (d,f,w) computes: sum over i of (fs_i ^ ws_i ? -1 : +1) * fmag_i * wmag_i.
//   - fs/fmag come from i_feature[d][f].mantissa[i].
//   - ws/wmag come from i_filter[d][w].mantissa[i].
// - Sign-magnitude decode: sign bit set with magnitude 0 ("-0") gives product 0.
// - Widths:
//   - PROD_W = FEATURE_WIDTH + FILTER_WIDTH - 1 (signed).
//   - SUM_W = PROD_W + $clog2(DOT_SIZE) (signed); no internal overflow possible.
//   - Output is SUM_W[DOT_OUTPUT_WIDTH-1:0]: wrap-around truncation, no saturation.
//   - If DOT_OUTPUT_WIDTH > SUM_W, the sum is sign-extended.
// - Pipeline, free-running with no stall:
//   - S1: register the input mantissas and i_valid.
//   - S2: signed products.
//   - S3: full adder tree.
//   - S4..S(DOT_LATENCY): pure delay stages; retimable.
// - Latency: the result for the inputs sampled at edge N is visible after edge N+DOT_LATENCY-1.
//   This matches the checker's DOT_LATENCY-deep mantissa delay line.
// - Data registers are computed every cycle regardless of i_valid.
//   Results for invalid cycles are still correct dot products of whatever was on the bus.
// - Throughput: one vector per cycle. Valid bubbles are preserved in position and order.
// - Reset:
//   - Every pipeline register, including data, clears to 0.
//   - o_valid = 0 and o_dot_result = 0 the cycle after reset is sampled high.
// - Reset mid-operation: in-flight items are discarded. o_valid stays 0 until a new
//   i_valid has traversed DOT_LATENCY stages after release.
// - Elaboration $error if DOT_LATENCY < 3, DOT_SIZE < 1, or either mantissa width < 2.
// STRUCTURE
// - pe_types package additions:
//   - function dot_prod_width(cfg)
//   - function dot_sum_width(cfg)
//   - typedef dot_sum_t#(cfg)::t
// - Sub-module pe_dot_pipe_lane:
//   - One lane: sign decode, DOT_SIZE multipliers, adder tree, delay stages.
//   - Instantiated NUM_DOTS*NUM_FEATURES*NUM_FILTERS times from a generate loop.
// - The top level owns the valid shift register and the input registers. Lanes share the S1 registers.
// - No simulation-only code in this module; pe_dot_checker binds alongside it.
// TESTING (default cfg unless noted; pe_dot_checker instantiated and must report zero errors)
// - All fmag=1 (+), all wmag=2 (+), i_valid=1 at cycle 0
//     -> o_valid=1 at cycle 4; every lane = 16; o_valid=0 for cycles 1-3.
// - Element 0 only: feature +31, filter -31; all other elements 0
//     -> result -961 = 0xFC3F. Same vector with feature sign=1, mag=0 -> result 0.
// - All elements +31 x +31 -> 7688 (0x1E08). All elements +31 x -31 -> -7688 (0xE1F8).
//   With DOT_OUTPUT_WIDTH=12, +31 x +31 -> 0xE08 (wrap).
// - Lane independence: feature0 all +1, feature1 all +3, filter0 all +1, filter1 all -2
//     -> [0][0][0]=8, [0][0][1]=-16, [0][1][0]=24, [0][1][1]=-48.
// - Back-to-back vectors with i_valid pattern 1,1,0,1, with k-th vector all +k x +1
//     -> o_valid pattern 1,1,0,1 from cycle 4; results 8,16,(don't care),32, in order.
// - Assert reset for 1 cycle with 3 valid items in flight
//     -> o_valid=0 and results=0 the next cycle; no stale valid ever emerges.
//   A new item issued after release appears exactly DOT_LATENCY cycles later.

Source files
------------

// File: rtl/pe_dot_pipe_pkg.sv
// Shared configuration and width helpers for the block-floating-point dot-product pipeline.
// The exponents are handled downstream. Only mantissa geometry lives here.
package pe_dot_pipe_pkg;

  typedef struct packed {
    int NUM_DOTS;
    int NUM_FEATURES;
    int NUM_FILTERS;
    int DOT_SIZE;
    int FEATURE_WIDTH;
    int FILTER_WIDTH;
    int DOT_OUTPUT_WIDTH;
    int DOT_LATENCY;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{
    NUM_DOTS:         1,
    NUM_FEATURES:     2,
    NUM_FILTERS:      2,
    DOT_SIZE:         8,
    FEATURE_WIDTH:    6,
    FILTER_WIDTH:     6,
    DOT_OUTPUT_WIDTH: 16,
    DOT_LATENCY:      4
  };

  // A signed product needs both magnitudes plus a single sign bit.
  function automatic int dot_prod_width(input pe_cfg_t cfg);
    return cfg.FEATURE_WIDTH + cfg.FILTER_WIDTH - 1;
  endfunction

  function automatic int dot_sum_width(input pe_cfg_t cfg);
    return dot_prod_width(cfg) + $clog2(cfg.DOT_SIZE);
  endfunction

endpackage

// File: rtl/pe_dot_pipe_if.sv
// Feature/filter input bus and dot-result output bus of one PE dot-product engine.
interface pe_dot_pipe_if
  import pe_dot_pipe_pkg::*;
#(
  parameter pe_cfg_t cfg = PE_CFG_DEFAULT
) ();

  logic i_valid;
  logic [cfg.NUM_DOTS-1:0][cfg.NUM_FEATURES-1:0][cfg.DOT_SIZE-1:0][cfg.FEATURE_WIDTH-1:0] i_feature;
  logic [cfg.NUM_DOTS-1:0][cfg.NUM_FILTERS-1:0][cfg.DOT_SIZE-1:0][cfg.FILTER_WIDTH-1:0]   i_filter;
  logic o_valid;
  logic [cfg.NUM_DOTS-1:0][cfg.NUM_FEATURES-1:0][cfg.NUM_FILTERS-1:0][cfg.DOT_OUTPUT_WIDTH-1:0] o_dot_result;

  modport master (
    output i_valid, i_feature, i_filter,
    input  o_valid, o_dot_result
  );

  modport slave (
    input  i_valid, i_feature, i_filter,
    output o_valid, o_dot_result
  );

endinterface

// File: rtl/pe_dot_pipe_lane.sv
// One dot-product lane: sign-magnitude products (S2), full sum (S3), then pure delay stages.
module pe_dot_pipe_lane
  import pe_dot_pipe_pkg::*;
#(
  parameter pe_cfg_t cfg = PE_CFG_DEFAULT
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic [cfg.DOT_SIZE-1:0][cfg.FEATURE_WIDTH-1:0]       feature_i,
  input  logic [cfg.DOT_SIZE-1:0][cfg.FILTER_WIDTH-1:0]        filter_i,
  output logic [cfg.DOT_OUTPUT_WIDTH-1:0]                      dot_o
);

  localparam int DS     = cfg.DOT_SIZE;
  localparam int FW     = cfg.FEATURE_WIDTH;
  localparam int WW     = cfg.FILTER_WIDTH;
  localparam int OW     = cfg.DOT_OUTPUT_WIDTH;
  localparam int DLY    = cfg.DOT_LATENCY - 3;
  localparam int PROD_W = dot_prod_width(cfg);
  localparam int SUM_W  = dot_sum_width(cfg);

  logic        [PROD_W-2:0] mag     [DS];
  logic signed [PROD_W-1:0] prod_d  [DS];
  logic signed [PROD_W-1:0] prod_q  [DS];
  logic signed [SUM_W-1:0]  sum_d;
  logic        [OW-1:0]     res_d;
  logic        [OW-1:0]     res_q;

  // A "-0" operand has zero magnitude, so negation still yields 0.
  always_comb begin
    for (int i = 0; i < DS; i++) begin
      mag[i]    = (PROD_W-1)'(feature_i[i][FW-2:0]) * (PROD_W-1)'(filter_i[i][WW-2:0]);
      prod_d[i] = (feature_i[i][FW-1] ^ filter_i[i][WW-1]) ? -$signed({1'b0, mag[i]})
                                                          :  $signed({1'b0, mag[i]});
    end
  end

  // The size cast sign-extends or wrap-truncates to the output width.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < DS; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
    res_d = OW'(sum_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DS; i++) prod_q[i] <= '0;
      res_q <= '0;
    end else begin
      for (int i = 0; i < DS; i++) prod_q[i] <= prod_d[i];
      res_q <= res_d;
    end
  end

  if (DLY == 0) begin : g_no_delay
    assign dot_o = res_q;
  end else begin : g_delay
    logic [OW-1:0] dly_q [DLY];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < DLY; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= res_q;
        for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign dot_o = dly_q[DLY-1];
  end

endmodule

// File: rtl/pe_dot_pipe.sv
// Pipelined dot-product engine: shared input registers (S1), valid shift register,
// and one lane per (dot, feature, filter) combination.
module pe_dot_pipe
  import pe_dot_pipe_pkg::*;
#(
  parameter pe_cfg_t cfg      = PE_CFG_DEFAULT,
  parameter int      CHAIN_ID = 0,
  parameter int      PE_ID    = 0
) (
  input  logic        clock,
  input  logic        reset,
  pe_dot_pipe_if.slave bus
);

  localparam int ND = cfg.NUM_DOTS;
  localparam int NF = cfg.NUM_FEATURES;
  localparam int NW = cfg.NUM_FILTERS;
  localparam int DS = cfg.DOT_SIZE;
  localparam int FW = cfg.FEATURE_WIDTH;
  localparam int WW = cfg.FILTER_WIDTH;
  localparam int OW = cfg.DOT_OUTPUT_WIDTH;
  localparam int L  = cfg.DOT_LATENCY;

  if (L < 3 || DS < 1 || FW < 2 || WW < 2) begin : g_cfg_check
    $error("pe_dot_pipe chain %0d pe %0d: illegal cfg (latency %0d, size %0d, widths %0d/%0d)",
           CHAIN_ID, PE_ID, L, DS, FW, WW);
  end

  logic [ND-1:0][NF-1:0][DS-1:0][FW-1:0] feat_q;
  logic [ND-1:0][NW-1:0][DS-1:0][WW-1:0] filt_q;
  logic [L-1:0]                          vld_d;
  logic [L-1:0]                          vld_q;
  logic [ND-1:0][NF-1:0][NW-1:0][OW-1:0] dot;

  always_comb begin
    vld_d = {vld_q[L-2:0], bus.i_valid};
  end

  // Data is captured every cycle; only the valid bit tracks which slots are real.
  always_ff @(posedge clock) begin
    if (reset) begin
      feat_q <= '0;
      filt_q <= '0;
      vld_q  <= '0;
    end else begin
      feat_q <= bus.i_feature;
      filt_q <= bus.i_filter;
      vld_q  <= vld_d;
    end
  end

  for (genvar d = 0; d < ND; d++) begin : g_dot
    for (genvar f = 0; f < NF; f++) begin : g_feat
      for (genvar w = 0; w < NW; w++) begin : g_filt
        pe_dot_pipe_lane #(.cfg(cfg)) u_lane (
          .clock     (clock),
          .reset     (reset),
          .feature_i (feat_q[d][f]),
          .filter_i  (filt_q[d][w]),
          .dot_o     (dot[d][f][w])
        );
      end
    end
  end

  assign bus.o_dot_result = dot;
  assign bus.o_valid      = vld_q[L-1];

endmodule

// File: tb/tb_pe_dot_pipe.sv
// Directed bench for pe_dot_pipe: default config plus a 12-bit-output copy for the wrap case.
module tb_pe_dot_pipe;
  import pe_dot_pipe_pkg::*;

  localparam pe_cfg_t CFG_A = PE_CFG_DEFAULT;
  localparam pe_cfg_t CFG_B = '{
    NUM_DOTS: 1, NUM_FEATURES: 2, NUM_FILTERS: 2, DOT_SIZE: 8,
    FEATURE_WIDTH: 6, FILTER_WIDTH: 6, DOT_OUTPUT_WIDTH: 12, DOT_LATENCY: 4
  };

  logic clock = 1'b0;
  logic reset;
  logic inValid;
  logic [0:0][1:0][7:0][5:0] feat;
  logic [0:0][1:0][7:0][5:0] filt;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clock = ~clock;

  pe_dot_pipe_if #(.cfg(CFG_A)) busA ();
  pe_dot_pipe_if #(.cfg(CFG_B)) busB ();

  assign busA.i_valid   = inValid;
  assign busA.i_feature = feat;
  assign busA.i_filter  = filt;
  assign busB.i_valid   = inValid;
  assign busB.i_feature = feat;
  assign busB.i_filter  = filt;

  pe_dot_pipe #(.cfg(CFG_A), .CHAIN_ID(0), .PE_ID(0)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA.slave)
  );

  pe_dot_pipe #(.cfg(CFG_B), .CHAIN_ID(0), .PE_ID(1)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB.slave)
  );

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Fill every element of both feature and both filter vectors.
  task automatic applyStimulus(input logic [5:0] f0, input logic [5:0] f1,
                               input logic [5:0] w0, input logic [5:0] w1, input logic v);
    for (int i = 0; i < 8; i++) begin
      feat[0][0][i] = f0;
      feat[0][1][i] = f1;
      filt[0][0][i] = w0;
      filt[0][1][i] = w1;
    end
    inValid = v;
  endtask

  task automatic checkLanes(input string tag, input logic [15:0] e00, input logic [15:0] e01,
                            input logic [15:0] e10, input logic [15:0] e11);
    checkOutput({tag, "_000"}, {16'h0, busA.o_dot_result[0][0][0]}, {16'h0, e00});
    checkOutput({tag, "_001"}, {16'h0, busA.o_dot_result[0][0][1]}, {16'h0, e01});
    checkOutput({tag, "_010"}, {16'h0, busA.o_dot_result[0][1][0]}, {16'h0, e10});
    checkOutput({tag, "_011"}, {16'h0, busA.o_dot_result[0][1][1]}, {16'h0, e11});
  endtask

  // One valid vector followed by bubbles, ending at the cycle its result appears.
  task automatic runVector(input string tag);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (3) tick();
    checkOutput({tag, "_valid"}, {31'h0, busA.o_valid}, 32'h1);
  endtask

  logic vPat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset   = 1'b1;
    inValid = 1'b0;
    feat    = '0;
    filt    = '0;
    tick();
    tick();
    checkOutput("reset_valid", {31'h0, busA.o_valid}, 32'h0);
    checkLanes("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    reset = 1'b0;

    // 8 x (1*2) = 16 everywhere; first result exactly four cycles after issue
    applyStimulus(6'd1, 6'd1, 6'd2, 6'd2, 1'b1);
    tick();
    inValid = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      checkOutput($sformatf("lat_valid_c%0d", n), {31'h0, busA.o_valid}, 32'h0);
      tick();
    end
    checkOutput("lat_valid_c4", {31'h0, busA.o_valid}, 32'h1);
    checkLanes("ones", 16'd16, 16'd16, 16'd16, 16'd16);
    checkOutput("ones_w12", {20'h0, busB.o_dot_result[0][0][0]}, 32'h010);

    // Element 0 only: +31 x -31 = -961
    applyStimulus(6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    feat[0][0][0] = 6'h1F;
    feat[0][1][0] = 6'h1F;
    filt[0][0][0] = 6'h3F;
    filt[0][1][0] = 6'h3F;
    runVector("elem0");
    checkLanes("elem0", 16'hFC3F, 16'hFC3F, 16'hFC3F, 16'hFC3F);

    // Negative zero on the feature side kills the product
    feat[0][0][0] = 6'h20;
    feat[0][1][0] = 6'h20;
    runVector("negzero");
    checkLanes("negzero", 16'h0, 16'h0, 16'h0, 16'h0);

    // Full-scale positive and negative sums, plus 12-bit wrap
    applyStimulus(6'h1F, 6'h1F, 6'h1F, 6'h1F, 1'b0);
    runVector("maxpos");
    checkLanes("maxpos", 16'h1E08, 16'h1E08, 16'h1E08, 16'h1E08);
    checkOutput("maxpos_w12", {20'h0, busB.o_dot_result[0][1][1]}, 32'hE08);

    applyStimulus(6'h1F, 6'h1F, 6'h3F, 6'h3F, 1'b0);
    runVector("maxneg");
    checkLanes("maxneg", 16'hE1F8, 16'hE1F8, 16'hE1F8, 16'hE1F8);
    checkOutput("maxneg_w12", {20'h0, busB.o_dot_result[0][0][1]}, 32'h1F8);

    // Lane independence: features +1/+3, filters +1/-2
    applyStimulus(6'd1, 6'd3, 6'd1, 6'h22, 1'b0);
    runVector("lanes");
    checkLanes("lanes", 16'd8, 16'hFFF0, 16'd24, 16'hFFD0);

    // Back-to-back with a bubble: vector k is all +k x +1 -> 8k
    for (int c = 0; c < 9; c++) begin
      if (c < 4) applyStimulus(6'(c + 1), 6'(c + 1), 6'd1, 6'd1, vPat[c]);
      else       applyStimulus(6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
      tick();
      if (c >= 3) begin
        checkOutput($sformatf("b2b_valid_%0d", c - 3), {31'h0, busA.o_valid}, {31'h0, vPat[c - 3]});
        if (vPat[c - 3])
          checkOutput($sformatf("b2b_result_%0d", c - 3), {16'h0, busA.o_dot_result[0][1][0]},
                      32'(8 * (c - 2)));
      end
    end

    // Three valid items in flight, then a one-cycle reset
    applyStimulus(6'd5, 6'd5, 6'd1, 6'd1, 1'b1);
    repeat (3) tick();
    reset   = 1'b1;
    inValid = 1'b0;
    tick();
    checkOutput("midreset_valid", {31'h0, busA.o_valid}, 32'h0);
    checkOutput("midreset_valid_w12", {31'h0, busB.o_valid}, 32'h0);
    checkLanes("midreset", 16'h0, 16'h0, 16'h0, 16'h0);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checkOutput($sformatf("nostale_%0d", n), {31'h0, busA.o_valid}, 32'h0);
    end

    applyStimulus(6'd2, 6'd2, 6'd1, 6'd1, 1'b1);
    tick();
    inValid = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      checkOutput($sformatf("post_valid_c%0d", n), {31'h0, busA.o_valid}, 32'h0);
      tick();
    end
    checkOutput("post_valid_c4", {31'h0, busA.o_valid}, 32'h1);
    checkLanes("post", 16'd16, 16'd16, 16'd16, 16'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
